fc_scheduler: RTL



---
 rtl/fc_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fc_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fc_scheduler
// Purpose  : Time-multiplexed sequencer for the fully connected stage. One
//            shared Q16.16 multiply-accumulate walks every output neuron and
//            every flattened input, issuing read addresses to the activation,
//            weight and bias memories and returning one result per neuron
//            over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fc_scheduler #(
    parameter int INPUT_SIZE  = 256,
    parameter int NUM_OUTPUTS = 10,
    parameter int DATA_W      = 32,
    parameter int FRAC_BITS   = 16,
    parameter int AW_ACT      = $clog2(INPUT_SIZE),
    parameter int AW_WT       = $clog2(INPUT_SIZE * NUM_OUTPUTS),
    parameter int AW_OUT      = $clog2(NUM_OUTPUTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_re,
    output logic [AW_ACT-1:0] act_addr,
    input  logic [DATA_W-1:0] act_rdata,
    output logic [AW_WT-1:0]  wt_addr,
    input  logic [DATA_W-1:0] wt_rdata,
    output logic [AW_OUT-1:0] bias_addr,
    input  logic [DATA_W-1:0] bias_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW_OUT-1:0] out_index,
    output logic [DATA_W-1:0] out_data
);

    // Last MAC index, and the last index for which a further read is issued.
    // INPUT_SIZE is assumed to be at least 2.
    localparam logic [AW_ACT-1:0] c_LAST_C = AW_ACT'(INPUT_SIZE - 1);
    localparam logic [AW_ACT-1:0] c_PRE_C  = AW_ACT'(INPUT_SIZE - 2);
    localparam logic [AW_OUT-1:0] c_LAST_O = AW_OUT'(NUM_OUTPUTS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BIAS = 3'd1,
        S_MAC  = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [AW_OUT-1:0] r_o;
    logic [AW_ACT-1:0] r_c;
    logic [AW_ACT-1:0] r_act_addr;
    logic [AW_WT-1:0]  r_wt_addr;
    logic [AW_OUT-1:0] r_bias_addr;
    logic [DATA_W-1:0] r_acc;

    logic signed [2*DATA_W-1:0] w_full;
    logic        [DATA_W-1:0]   w_prod;
    logic        [DATA_W-1:0]   w_acc_base;

    // Full-precision product; the arithmetic shift drops fractional bits
    // toward minus infinity and the cast keeps the Q16.16 window.
    assign w_full     = $signed(act_rdata) * $signed(wt_rdata);
    assign w_prod     = DATA_W'(w_full >>> FRAC_BITS);
    assign w_acc_base = (r_c == '0) ? bias_rdata : r_acc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control outputs decoded from the current state.
    always_comb begin
        w_state_nxt = r_state;
        mem_re      = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_BIAS;
                end
            end
            S_BIAS: begin
                mem_re      = 1'b1;
                w_state_nxt = S_MAC;
            end
            S_MAC: begin
                if (r_c != c_LAST_C) begin
                    mem_re = 1'b1;
                end else begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = (r_o == c_LAST_O) ? S_DONE : S_BIAS;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Counters, address generators and accumulator. Addresses are
    // pre-advanced one cycle ahead so that each MAC cycle consumes the data
    // requested in the previous cycle; the weight address simply counts on
    // across neurons, so no multiplier is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o         <= '0;
            r_c         <= '0;
            r_act_addr  <= '0;
            r_wt_addr   <= '0;
            r_bias_addr <= '0;
            r_acc       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_o         <= '0;
                        r_act_addr  <= '0;
                        r_wt_addr   <= '0;
                        r_bias_addr <= '0;
                    end
                end
                S_BIAS: begin
                    r_c        <= '0;
                    r_act_addr <= r_act_addr + 1'b1;
                    r_wt_addr  <= r_wt_addr + 1'b1;
                end
                S_MAC: begin
                    r_acc <= w_acc_base + w_prod;
                    if (r_c != c_LAST_C) begin
                        r_c <= r_c + 1'b1;
                    end
                    if (r_c < c_PRE_C) begin
                        r_act_addr <= r_act_addr + 1'b1;
                        r_wt_addr  <= r_wt_addr + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (out_ready && (r_o != c_LAST_O)) begin
                        r_o         <= r_o + 1'b1;
                        r_bias_addr <= r_o + 1'b1;
                        r_act_addr  <= '0;
                        r_wt_addr   <= r_wt_addr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign act_addr  = r_act_addr;
    assign wt_addr   = r_wt_addr;
    assign bias_addr = r_bias_addr;
    assign out_data  = r_acc;
    assign out_index = r_o;

endmodule
`default_nettype wire
